ir_packet_receiver: RTL
=======================

Name: ir_packet_receiver

Overview:
- Decodes the demodulated IR envelope from a photodiode front end back into the 4-bit car command that the IR transmitter sends.
- Measures each burst and gap in carrier periods, counted on `tick`, which is driven by the FrequencyGenerator `out_pulse`.
- Validates the frame structure: start burst, car-select burst, then four data bits.
- Outputs the command with a one-cycle valid strobe, or flags a frame error.

Parameters:
- CNT_W, 9: width of the duration counter; saturates at 2^CNT_W-1.
- START_LEN, 191: start burst length, in ticks.
- GAP_LEN, 25: gap length following every burst, in ticks.
- SEL_LEN, 47: car-select burst length that this car accepts.
- ASSERT_LEN, 47: burst length for a data bit of 1.
- DEASSERT_LEN, 22: burst length for a data bit of 0.
- TOL, 4: a duration d matches length L iff |d-L| <= TOL. The ASSERT and DEASSERT windows must not overlap.

Ports:
- sys_clk, in, 1: system clock, 100 MHz.
- reset, in, 1: asynchronous, active-low reset.
- tick, in, 1: one-cycle pulse per carrier period.
- ir_in, in, 1: envelope, asynchronous; 1 = carrier present.
- cmd, out, 4: last decoded command. Bit mapping: [0] right, [1] left, [2] backward, [3] forward.
- cmd_valid, out, 1: one-cycle strobe; `cmd` was updated this cycle.
- frame_error, out, 1: one-cycle strobe; a frame was aborted.
- busy, out, 1: high in every state except IDLE.

Behaviour:
- Reset (reset=0, any time, including mid-frame):
  - state=IDLE, cmd=0, cmd_valid=0, frame_error=0, busy=0.
  - Counter and bit index cleared; synchroniser flops = 0.
- Input path:
  - 2-flop synchroniser on `ir_in`, plus a third delay flop for edge detection.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- Duration counter:
  - Cleared to 0 on every rise or fall.
  - Otherwise increments on `tick`; saturates at max.
  - On an edge, the value before clearing is the duration of the level that just ended.
- States: IDLE, START, SEL_GAP, SEL, BIT_GAP, BIT.
  - IDLE: on rise -> START.
  - START (high): on fall, if duration matches START_LEN -> SEL_GAP; else -> IDLE, no error (noise).
  - SEL_GAP (low): on rise, if duration matches GAP_LEN -> SEL; else frame_error.
  - SEL (high): on fall, if duration matches SEL_LEN -> BIT_GAP with bit index=0. Otherwise the packet is for another car -> IDLE silently, no error.
  - BIT_GAP (low): on rise, if duration matches GAP_LEN -> BIT; else frame_error.
  - BIT (high): on fall:
    - Match ASSERT_LEN -> shift in 1; match DEASSERT_LEN -> shift in 0; neither -> frame_error.
    - Bits arrive in order right, left, backward, forward: the first bit goes to cmd[0], the fourth to cmd[3].
    - After bits 0-2 -> BIT_GAP.
    - After the 4th valid bit: load all 4 bits into `cmd` at once, pulse cmd_valid, -> IDLE.
- Gap timeout: in SEL_GAP or BIT_GAP, if the counter exceeds GAP_LEN+TOL while still low -> frame_error, -> IDLE. Detection happens without waiting for the next rise.
- frame_error:
  - One-cycle pulse; always -> IDLE.
  - `cmd` is unchanged, and partial bits are never exposed on `cmd`.
- Resync: in any busy state, a high burst whose duration matches START_LEN at its fall pulses frame_error and -> SEL_GAP, i.e. the new frame is accepted.
- Latency: cmd_valid is high on the 3rd sys_clk posedge after `ir_in` falls, counting the first posedge that samples the low level as edge 1. `cmd` updates on that same edge.
- Hold: `cmd` holds its value until the next valid frame or reset.
- Simultaneous events: an edge and a `tick` in the same cycle -> the clear wins, and the counter becomes 0.
- Output registering: all outputs are registered; no combinational path from `ir_in` or `tick` to any output.

Test Plan:
- Reset: hold reset=0 with `ir_in` toggling -> cmd=0, cmd_valid=0, frame_error=0, busy=0 throughout. Release reset -> busy rises only after the first rise of `ir_in`.
- Valid frame: tick every 4 sys_clk cycles. Send start 191, gap 25, sel 47, gap 25, bits 47/22/22/47 -> exactly one cmd_valid pulse, cmd=4'b1001, no frame_error. cmd_valid appears 3 posedges after the final fall.
- Tolerance edges:
  - Start 187 and bits 51/18/43/26 -> cmd=4'b0101, valid.
  - Same frame with start 186 -> no cmd_valid, no frame_error, back in IDLE.
- Wrong car: sel burst 30 ticks -> silent return to IDLE, cmd keeps its previous value, no strobes.
- Error cases:
  - Bit burst 35 ticks -> one frame_error pulse, cmd unchanged.
  - Gap held low for 30 ticks after the 2nd bit -> frame_error, raised while `ir_in` is still low.
- Reset mid-frame: assert reset=0 during the 3rd bit, release, then send a full frame with bits 22/47/47/22 -> cmd=4'b0110, exactly one cmd_valid pulse.

Source files
------------

// File: rtl/ir_packet_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ir_packet_receiver
// Brief  : Measures IR envelope bursts/gaps in carrier ticks and decodes the
//          start / car-select / 4-bit command frame.
// Rev    : 1.0  initial release
// ============================================================================
module ir_packet_receiver #(
  parameter int CNT_W        = 9,
  parameter int START_LEN    = 191,
  parameter int GAP_LEN      = 25,
  parameter int SEL_LEN      = 47,
  parameter int ASSERT_LEN   = 47,
  parameter int DEASSERT_LEN = 22,
  parameter int TOL          = 4
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ir_in,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       frame_error,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    SEL_GAP = 3'd2,
    SEL     = 3'd3,
    BIT_GAP = 3'd4,
    BIT     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic             r_s1, r_s2, r_s3;
  logic             w_rise, w_fall;
  logic [CNT_W-1:0] r_cnt;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cmd, w_cmd_nxt;
  logic [3:0]       r_bits, w_bits_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic             r_cmd_valid, w_cmd_valid_nxt;
  logic             r_frame_error, w_frame_error_nxt;
  logic             r_busy;

  logic             w_is_start, w_is_gap, w_is_sel, w_is_one, w_is_zero;
  logic             w_gap_over;

  function automatic logic f_match(input logic [CNT_W-1:0] dur, input int len);
    int d;
    d = int'(dur);
    return (d >= len - TOL) && (d <= len + TOL);
  endfunction

  // Two flops for metastability, a third to detect level changes.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= ir_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  // On an edge the counter still holds the length of the level that just ended.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_rise || w_fall) begin
      r_cnt <= '0;
    end else if (tick && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_is_start = f_match(r_cnt, START_LEN);
  assign w_is_gap   = f_match(r_cnt, GAP_LEN);
  assign w_is_sel   = f_match(r_cnt, SEL_LEN);
  assign w_is_one   = f_match(r_cnt, ASSERT_LEN);
  assign w_is_zero  = f_match(r_cnt, DEASSERT_LEN);
  assign w_gap_over = int'(r_cnt) > (GAP_LEN + TOL);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cmd         <= 4'd0;
      r_bits        <= 4'd0;
      r_idx         <= 2'd0;
      r_cmd_valid   <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd         <= w_cmd_nxt;
      r_bits        <= w_bits_nxt;
      r_idx         <= w_idx_nxt;
      r_cmd_valid   <= w_cmd_valid_nxt;
      r_frame_error <= w_frame_error_nxt;
      r_busy        <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cmd_nxt         = r_cmd;
    w_bits_nxt        = r_bits;
    w_idx_nxt         = r_idx;
    w_cmd_valid_nxt   = 1'b0;
    w_frame_error_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_rise) w_state_nxt = START;
      end

      START: begin
        // A mismatched start is treated as noise, not a broken frame.
        if (w_fall) w_state_nxt = w_is_start ? SEL_GAP : IDLE;
      end

      SEL_GAP: begin
        if (w_rise) begin
          if (w_is_gap) begin
            w_state_nxt = SEL;
          end else begin
            w_frame_error_nxt = 1'b1;
            w_state_nxt       = IDLE;
          end
        end else if (w_gap_over) begin
          w_frame_error_nxt = 1'b1;
          w_state_nxt       = IDLE;
        end
      end

      SEL: begin
        if (w_fall) begin
          if (w_is_start) begin
            w_frame_error_nxt = 1'b1;
            w_state_nxt       = SEL_GAP;
          end else if (w_is_sel) begin
            w_idx_nxt   = 2'd0;
            w_bits_nxt  = 4'd0;
            w_state_nxt = BIT_GAP;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      BIT_GAP: begin
        if (w_rise) begin
          if (w_is_gap) begin
            w_state_nxt = BIT;
          end else begin
            w_frame_error_nxt = 1'b1;
            w_state_nxt       = IDLE;
          end
        end else if (w_gap_over) begin
          w_frame_error_nxt = 1'b1;
          w_state_nxt       = IDLE;
        end
      end

      BIT: begin
        if (w_fall) begin
          if (w_is_start) begin
            w_frame_error_nxt = 1'b1;
            w_state_nxt       = SEL_GAP;
          end else if (w_is_one || w_is_zero) begin
            if (r_idx == 2'd3) begin
              // Partial bits stay internal until the whole command is known.
              w_cmd_nxt       = {w_is_one, r_bits[2:0]};
              w_cmd_valid_nxt = 1'b1;
              w_state_nxt     = IDLE;
            end else begin
              w_bits_nxt[r_idx] = w_is_one;
              w_idx_nxt         = r_idx + 2'd1;
              w_state_nxt       = BIT_GAP;
            end
          end else begin
            w_frame_error_nxt = 1'b1;
            w_state_nxt       = IDLE;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign cmd         = r_cmd;
  assign cmd_valid   = r_cmd_valid;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

endmodule
`default_nettype wire
